// File: rtl/buzzer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : buzzer_sequencer
// Description : Beep-pattern generator: N beeps of a square-wave tone with
//               programmable tone half-period, beep length and inter-beep gap.
// Revision    : 1.0  initial release
// ============================================================================
module buzzer_sequencer #(
  parameter int TICK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        start,
  input  logic [15:0] half_period,
  input  logic [15:0] on_time,
  input  logic [15:0] off_time,
  input  logic [7:0]  repeat_cnt,
  output logic        buzz_out,
  output logic        busy,
  output logic        done
);

  localparam int                 c_PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICK_DIV - 1);
  localparam logic [c_PRE_W-1:0] c_PRE_ONE  = c_PRE_W'(1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_ON   = 2'd1;
  localparam logic [1:0] c_OFF  = 2'd2;

  logic [1:0]         r_state, w_next_state;
  logic [15:0]        r_hp, r_on, r_off;
  logic [7:0]         r_rem;
  logic [c_PRE_W-1:0] r_pre;
  logic [15:0]        r_tick, r_tone;
  logic               r_buzz, r_busy, r_done;

  logic [15:0]        w_hp_n, w_on_n, w_off_n;
  logic [7:0]         w_rem_n;
  logic [c_PRE_W-1:0] w_pre_n;
  logic [15:0]        w_tick_n, w_tone_n;
  logic               w_buzz_n, w_busy_n, w_done_n;

  logic               w_start_ok, w_go, w_pre_last, w_on_end, w_off_end, w_last_beep;
  logic               w_tone_wrap;
  logic [15:0]        w_tone_last;
  logic [c_PRE_W-1:0] w_pre_adv;
  logic [15:0]        w_tick_adv;

  assign w_start_ok  = start & en;
  assign w_go        = w_start_ok && (repeat_cnt != 8'd0) && (on_time != 16'd0);
  assign w_pre_last  = (r_pre == c_PRE_LAST);
  assign w_on_end    = w_pre_last && (r_tick == r_on - 16'd1);
  // A zero gap still spends one cycle in OFF before the next beep.
  assign w_off_end   = (r_off == 16'd0) || (w_pre_last && (r_tick == r_off - 16'd1));
  assign w_last_beep = (r_rem == 8'd1);
  assign w_tone_last = (r_hp == 16'd0) ? 16'd0 : r_hp - 16'd1;
  assign w_tone_wrap = (r_tone == w_tone_last);
  assign w_pre_adv   = w_pre_last ? '0 : r_pre + c_PRE_ONE;
  assign w_tick_adv  = w_pre_last ? r_tick + 16'd1 : r_tick;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= c_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: if (w_go) w_next_state = c_ON;
      c_ON: begin
        if (!en)           w_next_state = c_IDLE;
        else if (w_on_end) w_next_state = w_last_beep ? c_IDLE : c_OFF;
      end
      c_OFF: begin
        if (!en)            w_next_state = c_IDLE;
        else if (w_off_end) w_next_state = c_ON;
      end
      default: w_next_state = c_IDLE;
    endcase
  end

  // Next values for counters, latched config and the registered outputs.
  always_comb begin
    w_hp_n   = r_hp;
    w_on_n   = r_on;
    w_off_n  = r_off;
    w_rem_n  = r_rem;
    w_pre_n  = r_pre;
    w_tick_n = r_tick;
    w_tone_n = r_tone;
    w_buzz_n = 1'b0;
    w_busy_n = 1'b0;
    w_done_n = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (w_start_ok) begin
          w_hp_n   = half_period;
          w_on_n   = on_time;
          w_off_n  = off_time;
          w_rem_n  = repeat_cnt;
          w_pre_n  = '0;
          w_tick_n = 16'd0;
          w_tone_n = 16'd0;
          if (w_go) begin
            w_buzz_n = 1'b1;
            w_busy_n = 1'b1;
          end else begin
            w_done_n = 1'b1;
          end
        end
      end
      c_ON: begin
        if (en) begin
          if (w_on_end) begin
            w_rem_n  = r_rem - 8'd1;
            w_pre_n  = '0;
            w_tick_n = 16'd0;
            w_busy_n = !w_last_beep;
            w_done_n = w_last_beep;
          end else begin
            w_pre_n  = w_pre_adv;
            w_tick_n = w_tick_adv;
            w_busy_n = 1'b1;
            if (w_tone_wrap) begin
              w_tone_n = 16'd0;
              w_buzz_n = ~r_buzz;
            end else begin
              w_tone_n = r_tone + 16'd1;
              w_buzz_n = r_buzz;
            end
          end
        end
      end
      c_OFF: begin
        if (en) begin
          w_busy_n = 1'b1;
          if (w_off_end) begin
            w_pre_n  = '0;
            w_tick_n = 16'd0;
            w_tone_n = 16'd0;
            w_buzz_n = 1'b1;
          end else begin
            w_pre_n  = w_pre_adv;
            w_tick_n = w_tick_adv;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hp   <= 16'd0;
      r_on   <= 16'd0;
      r_off  <= 16'd0;
      r_rem  <= 8'd0;
      r_pre  <= '0;
      r_tick <= 16'd0;
      r_tone <= 16'd0;
      r_buzz <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_hp   <= w_hp_n;
      r_on   <= w_on_n;
      r_off  <= w_off_n;
      r_rem  <= w_rem_n;
      r_pre  <= w_pre_n;
      r_tick <= w_tick_n;
      r_tone <= w_tone_n;
      r_buzz <= w_buzz_n;
      r_busy <= w_busy_n;
      r_done <= w_done_n;
    end
  end

  assign buzz_out = r_buzz;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_buzzer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_buzzer_sequencer
// Description : Directed self-checking bench for buzzer_sequencer (TICK_DIV=4).
// Revision    : 1.0  initial release
// ============================================================================
module tb_buzzer_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        start;
  logic [15:0] half_period;
  logic [15:0] on_time;
  logic [15:0] off_time;
  logic [7:0]  repeat_cnt;
  logic        buzz_out;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  buzzer_sequencer #(.TICK_DIV(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .start       (start),
    .half_period (half_period),
    .on_time     (on_time),
    .off_time    (off_time),
    .repeat_cnt  (repeat_cnt),
    .buzz_out    (buzz_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [15:0] hp, input logic [15:0] on_t,
                         input logic [15:0] off_t, input logic [7:0] rep);
    half_period = hp;
    on_time     = on_t;
    off_time    = off_t;
    repeat_cnt  = rep;
  endtask

  // Pulse start for one edge; returns in the first cycle after that edge.
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Reference trace for hp=2, on=3, off=2, rep=2 at TICK_DIV=4.
  function automatic logic std_buzz(input int i);
    if (i < 12) return ((i % 4) < 2);
    if (i < 20) return 1'b0;
    return (((i - 20) % 4) < 2);
  endfunction

  // Full reference pattern; at cycle disturb_at start and config are disturbed.
  task automatic run_std(input string tag, input int disturb_at);
    set_cfg(16'd2, 16'd3, 16'd2, 8'd2);
    pulse_start();
    for (int i = 0; i < 32; i++) begin
      check($sformatf("%s buzz[%0d]", tag, i), 32'(buzz_out), 32'(std_buzz(i)));
      check($sformatf("%s busy[%0d]", tag, i), 32'(busy), 32'd1);
      check($sformatf("%s done[%0d]", tag, i), 32'(done), 32'd0);
      if (i == disturb_at) begin
        start = 1'b1;
        set_cfg(16'd5, 16'd9, 16'd7, 8'd7);
      end
      step();
      start = 1'b0;
    end
    check({tag, " end busy"}, 32'(busy), 32'd0);
    check({tag, " end done"}, 32'(done), 32'd1);
    check({tag, " end buzz"}, 32'(buzz_out), 32'd0);
    step();
    check({tag, " post done"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    en = 1'b1;
    start = 1'b0;
    set_cfg(16'd0, 16'd0, 16'd0, 8'd0);
    step();
    step();
    check("reset buzz", 32'(buzz_out), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    rst = 1'b1;
    step();

    // Basic two-beep pattern.
    run_std("basic", -1);

    // Zero repeat count: done pulse only.
    set_cfg(16'd2, 16'd3, 16'd2, 8'd0);
    pulse_start();
    check("rep0 busy", 32'(busy), 32'd0);
    check("rep0 done", 32'(done), 32'd1);
    check("rep0 buzz", 32'(buzz_out), 32'd0);
    step();
    check("rep0 done clr", 32'(done), 32'd0);
    check("rep0 busy clr", 32'(busy), 32'd0);

    // Start with en low is ignored.
    en = 1'b0;
    set_cfg(16'd2, 16'd3, 16'd2, 8'd2);
    pulse_start();
    check("en0 start busy", 32'(busy), 32'd0);
    check("en0 start done", 32'(done), 32'd0);
    en = 1'b1;
    step();

    // Enable dropped in the fifth ON cycle.
    pulse_start();
    for (int i = 0; i < 4; i++) step();
    check("abort pre busy", 32'(busy), 32'd1);
    check("abort pre buzz", 32'(buzz_out), 32'd1);
    en = 1'b0;
    step();
    check("abort busy", 32'(busy), 32'd0);
    check("abort buzz", 32'(buzz_out), 32'd0);
    check("abort done", 32'(done), 32'd0);
    en = 1'b1;
    step();
    check("abort done2", 32'(done), 32'd0);
    run_std("after_abort", -1);

    // Restart and config change while busy must not disturb the pattern.
    run_std("busy_ign", 3);

    // Reset in the middle of OFF, with start and en asserted.
    set_cfg(16'd2, 16'd3, 16'd2, 8'd2);
    pulse_start();
    for (int i = 0; i < 14; i++) step();
    check("midoff busy", 32'(busy), 32'd1);
    check("midoff buzz", 32'(buzz_out), 32'd0);
    rst = 1'b0;
    start = 1'b1;
    step();
    check("rst buzz", 32'(buzz_out), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    rst = 1'b1;
    start = 1'b0;
    step();
    check("rst rel busy", 32'(busy), 32'd0);
    set_cfg(16'd2, 16'd1, 16'd2, 8'd1);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("short buzz[%0d]", i), 32'(buzz_out), 32'(i < 2));
      check($sformatf("short busy[%0d]", i), 32'(busy), 32'd1);
      step();
    end
    check("short end busy", 32'(busy), 32'd0);
    check("short end done", 32'(done), 32'd1);
    step();

    // half_period=0 and off_time=0: toggle every cycle, one-cycle gap.
    set_cfg(16'd0, 16'd1, 16'd0, 8'd2);
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      check($sformatf("fast buzz[%0d]", i), 32'(buzz_out),
            32'((i == 4) ? 1'b0 : (((i % 5) % 2) == 0)));
      check($sformatf("fast busy[%0d]", i), 32'(busy), 32'd1);
      step();
    end
    check("fast end busy", 32'(busy), 32'd0);
    check("fast end done", 32'(done), 32'd1);
    check("fast end buzz", 32'(buzz_out), 32'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
